// File: rtl/seg_pkg.sv
// seg_pkg: digit codes, marker words, FSM states, segment and anode tables for seg_scan_driver
package seg_pkg;
    localparam logic [3:0]  DIG_DASH   = 4'd10;
    localparam logic [3:0]  DIG_BLANK  = 4'd11;
    localparam logic [3:0]  DIG_ERR    = 4'd12;
    localparam logic [15:0] MARK_DASH  = 16'hAAAA;
    localparam logic [15:0] MARK_BLANK = 16'hBBBB;

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} conv_state_e;

    // Active-low segments {a,b,c,d,e,f,g,dp}; dp is always off.
    function automatic logic [7:0] seg_pat(input logic [3:0] code);
        case (code)
            4'd0:    seg_pat = 8'h03;
            4'd1:    seg_pat = 8'h9F;
            4'd2:    seg_pat = 8'h25;
            4'd3:    seg_pat = 8'h0D;
            4'd4:    seg_pat = 8'h99;
            4'd5:    seg_pat = 8'h49;
            4'd6:    seg_pat = 8'h41;
            4'd7:    seg_pat = 8'h1F;
            4'd8:    seg_pat = 8'h01;
            4'd9:    seg_pat = 8'h09;
            DIG_DASH: seg_pat = 8'hFD;
            DIG_ERR:  seg_pat = 8'h61;
            default: seg_pat = 8'hFF;
        endcase
    endfunction

    // Active-low one-hot anode; slot 0 is the leftmost digit AN[3].
    function automatic logic [3:0] an_pat(input logic [1:0] sel);
        case (sel)
            2'd0:    an_pat = 4'b0111;
            2'd1:    an_pat = 4'b1011;
            2'd2:    an_pat = 4'b1101;
            default: an_pat = 4'b1110;
        endcase
    endfunction
endpackage

// File: rtl/bcd_dd_iter.sv
// bcd_dd_iter: one-byte iterative double-dabble (shift-add-3), one bit per clock
// Ports: clk; clr async active-high reset; start_i loads bin_i and clears the
// accumulator; bcd_o = {hundreds, tens, ones}; done_o high during the last shift.
module bcd_dd_iter #(
    parameter int CONV_BITS = 8
) (
    input  logic                 clk,
    input  logic                 clr,
    input  logic                 start_i,
    input  logic [CONV_BITS-1:0] bin_i,
    output logic [11:0]          bcd_o,
    output logic                 done_o
);
    localparam int CW = $clog2(CONV_BITS + 1);

    logic [CONV_BITS-1:0] sh_q;
    logic [11:0]          acc_q, adj;
    logic [CW-1:0]        cnt_q;
    logic                 busy_q;

    always_comb begin
        adj = acc_q;
        for (int i = 0; i < 3; i++)
            if (acc_q[4*i +: 4] >= 4'd5) adj[4*i +: 4] = acc_q[4*i +: 4] + 4'd3;
    end

    assign done_o = busy_q && cnt_q == CW'(CONV_BITS - 1);
    assign bcd_o  = acc_q;

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            sh_q   <= '0;
            acc_q  <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b0;
        end else if (start_i) begin
            sh_q   <= bin_i;
            acc_q  <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b1;
        end else if (busy_q) begin
            acc_q  <= {adj[10:0], sh_q[CONV_BITS-1]};
            sh_q   <= sh_q << 1;
            cnt_q  <= cnt_q + 1'b1;
            busy_q <= !done_o;
        end
    end
endmodule

// File: rtl/seg_scan_driver.sv
// seg_scan_driver: countdown word -> BCD -> multiplexed 4-digit common-anode 7-segment display
// Ports: clk; clr async active-high reset; data_in {main secs, side secs};
// upd pulses when a new conversion loads; AN active-low digit enables (AN[3] leftmost);
// Seg active-low segments {a..g, dp}.
// Option: define LEADING_ZERO_BLANK_EN to blank a tens digit of 0.
module seg_scan_driver
    import seg_pkg::*;
#(
    parameter int SCAN_DIV  = 125000,
    parameter int CONV_BITS = 8
) (
    input  logic        clk,
    input  logic        clr,
    input  logic [15:0] data_in,
    output logic        upd,
    output logic [3:0]  AN,
    output logic [7:0]  Seg
);
    localparam int SW = $clog2(SCAN_DIV);
`ifdef LEADING_ZERO_BLANK_EN
    localparam bit LZB = 1'b1;
`else
    localparam bit LZB = 1'b0;
`endif

    conv_state_e   state_q, state_d;
    logic          start, done_m, done_s, wrap;
    logic [11:0]   bcd_m, bcd_s;
    logic [15:0]   shadow_q, disp_q, disp_d, show_q;
    logic [SW-1:0] cnt_q;
    logic [1:0]    sel_q;
    logic [3:0]    dig, an_q;
    logic [7:0]    seg_q;
    logic          upd_q;

    // Two digit codes {tens, ones} for one byte; a nonzero hundreds nibble means >99.
    function automatic logic [7:0] byte_codes(input logic [11:0] b);
        byte_codes = b[11:8] != 4'd0 ? {DIG_ERR, DIG_ERR}
                   : {(LZB && b[7:4] == 4'd0) ? DIG_BLANK : b[7:4], b[3:0]};
    endfunction

    bcd_dd_iter #(.CONV_BITS(CONV_BITS)) u_main (
        .clk(clk), .clr(clr), .start_i(start), .bin_i(data_in[8 +: CONV_BITS]),
        .bcd_o(bcd_m), .done_o(done_m)
    );
    bcd_dd_iter #(.CONV_BITS(CONV_BITS)) u_side (
        .clk(clk), .clr(clr), .start_i(start), .bin_i(data_in[0 +: CONV_BITS]),
        .bcd_o(bcd_s), .done_o(done_s)
    );

    always_comb begin
        state_d = state_q;
        start   = 1'b0;
        case (state_q)
            IDLE: begin
                start   = 1'b1;
                state_d = SHIFT;
            end
            SHIFT:   if (done_m && done_s) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign disp_d = shadow_q == MARK_DASH  ? {4{DIG_DASH}}
                  : shadow_q == MARK_BLANK ? {4{DIG_BLANK}}
                  : {byte_codes(bcd_m), byte_codes(bcd_s)};
    assign wrap   = cnt_q == SW'(SCAN_DIV - 1);
    assign dig    = show_q[{~sel_q, 2'b00} +: 4];
    assign AN     = an_q;
    assign Seg    = seg_q;
    assign upd    = upd_q;

    // show_q is the front buffer: it only takes disp_q at a slot boundary, so a
    // conversion finishing mid-slot (or on the boundary itself) shows from the next slot.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_q  <= IDLE;
            shadow_q <= '0;
            disp_q   <= {4{DIG_BLANK}};
            show_q   <= {4{DIG_BLANK}};
            cnt_q    <= '0;
            sel_q    <= '0;
            upd_q    <= 1'b0;
            an_q     <= 4'hF;
            seg_q    <= 8'hFF;
        end else begin
            state_q <= state_d;
            if (start) shadow_q <= data_in;
            if (state_q == DONE) disp_q <= disp_d;
            upd_q <= state_q == DONE;
            cnt_q <= wrap ? '0 : cnt_q + 1'b1;
            if (wrap) begin
                sel_q  <= sel_q + 1'b1;
                show_q <= disp_q;
            end
            an_q  <= an_pat(sel_q);
            seg_q <= seg_pat(dig);
        end
    end
endmodule

// File: tb/tb_seg_scan_driver.sv
// tb_seg_scan_driver: randomized self-checking bench for seg_scan_driver against a cycle-indexed reference model
module tb_seg_scan_driver;
    localparam int SCAN_DIV = 4;
`ifdef LEADING_ZERO_BLANK_EN
    localparam bit LZB = 1'b1;
`else
    localparam bit LZB = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        clr = 1'b1;
    logic [15:0] data_in = 16'h0;
    logic        upd;
    logic [3:0]  AN;
    logic [7:0]  Seg;
    int          n_chk = 0;
    int          n_fail = 0;

    seg_scan_driver #(.SCAN_DIV(SCAN_DIV), .CONV_BITS(8)) dut (
        .clk(clk), .clr(clr), .data_in(data_in), .upd(upd), .AN(AN), .Seg(Seg)
    );

    always #5 clk = ~clk;

    logic [7:0] pat_t [13] = '{8'h03, 8'h9F, 8'h25, 8'h0D, 8'h99, 8'h49, 8'h41,
                               8'h1F, 8'h01, 8'h09, 8'hFD, 8'hFF, 8'h61};

    // Display codes for one byte: ERR above 99, else decimal tens/ones.
    function automatic logic [7:0] byte_exp(input int b);
        int t;
        if (b > 99) return {4'd12, 4'd12};
        t = b / 10;
        if (LZB && t == 0) t = 11;
        return {4'(t), 4'(b % 10)};
    endfunction

    function automatic logic [15:0] codes(input logic [15:0] w);
        if (w == 16'hAAAA) return {4{4'd10}};
        if (w == 16'hBBBB) return {4{4'd11}};
        return {byte_exp(int'(w[15:8])), byte_exp(int'(w[7:0]))};
    endfunction

    // Reference timeline from reset release: edge k is the k-th rising edge.
    // Captures on edges 1,11,21..; display loads and upd on edges 10,20,..;
    // slot boundaries on multiples of SCAN_DIV; outputs lag the slot by one edge.
    int          e, m_sel;
    logic [15:0] m_cap, m_disp, m_front;
    logic [3:0]  m_an;
    logic [7:0]  m_seg;
    logic        m_upd;

    always @(posedge clk or posedge clr) begin
        if (clr) begin
            e <= 0; m_sel <= 0; m_cap <= '0;
            m_disp <= {4{4'd11}}; m_front <= {4{4'd11}};
            m_an <= 4'hF; m_seg <= 8'hFF; m_upd <= 1'b0;
        end else begin
            e <= e + 1;
            m_an <= ~(4'b1000 >> m_sel);
            m_seg <= pat_t[m_front[4*(3-m_sel) +: 4]];
            m_upd <= ((e + 1) % 10 == 0);
            if ((e + 1) % SCAN_DIV == 0) begin
                m_front <= m_disp;
                m_sel <= (m_sel + 1) % 4;
            end
            if (e % 10 == 0) m_cap <= data_in;
            if ((e + 1) % 10 == 0) m_disp <= codes(m_cap);
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step(input logic [15:0] d);
        @(negedge clk);
        check("AN", 32'(AN), 32'(m_an));
        check("Seg", 32'(Seg), 32'(m_seg));
        check("upd", 32'(upd), 32'(m_upd));
        data_in = d;
    endtask

    logic [15:0] w;

    initial begin
        repeat (3) step(16'h2328);
        clr = 1'b0;
        repeat (5) step(16'h2328);
        #3 clr = 1'b1;
        #1;
        check("clr_AN", 32'(AN), 32'hF);
        check("clr_Seg", 32'(Seg), 32'hFF);
        check("clr_upd", 32'(upd), 32'h0);
        step(16'h2328);
        clr = 1'b0;
        repeat (60) step(16'h2328);
        repeat (60) step(16'h1E05);
        repeat (40) step(16'hAAAA);
        repeat (40) step(16'hBBBB);
        repeat (40) step(16'hC863);
        for (int i = 0; i < 60; i++) step(((i / 3) % 2) != 0 ? 16'h0304 : 16'h0102);
        w = 16'h0;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                case ($urandom_range(0, 4))
                    0: w = 16'($urandom);
                    1: w = 16'hAAAA;
                    2: w = 16'hBBBB;
                    3: w = {8'($urandom_range(0, 99)), 8'($urandom_range(0, 99))};
                    default: w = {8'($urandom_range(0, 9)), 8'($urandom_range(100, 255))};
                endcase
            end
            step(w);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/seg_scan_driver.md
Name: seg_scan_driver

Overview:
Downstream display stage of the traffic-light controller. Consumes the controller's 16-bit countdown word: high byte = main-road seconds, low byte = side-road seconds, binary. Converts each byte to two BCD digits with an iterative shift-add-3 engine, maps the special marker words, and time-multiplexes four common-anode 7-segment digits. All outputs are registered.

Parameters:
SCAN_DIV, 125000, clk cycles per digit slot (≥2).
CONV_BITS, 8, width of each binary field; fixes conversion length.

Ports:
clk  in  1  system clock
clr  in  1  asynchronous active-high reset
data_in  in  16  countdown word; [15:8] main road, [7:0] side road
upd  out  1  one-cycle pulse when the display register loads a new conversion
AN  out  4  digit enables, active-low one-hot; AN[3] = leftmost digit
Seg  out  8  segments, active-low; [7:1] = a..g, [0] = dp (always 1)

Behaviour:
- Reset, asynchronous, on clr=1:
  - AN=4'b1111, Seg=8'hFF, upd=0.
  - Display register = four BLANK codes; FSM=IDLE; scan counter=0; sel=0.
  - clr asserted mid-conversion aborts the conversion; no partial result reaches the display.
- Digit codes (4-bit): 0-9 digits, 10 DASH (Seg 8'hFD), 11 BLANK (8'hFF), 12 ERR "E" (8'h61).
  - Digit patterns: 0 = 8'h03, 1 = 8'h9F, 2 = 8'h25, 3 = 8'h0D, 4 = 8'h99, 5 = 8'h49, 6 = 8'h41, 7 = 8'h1F, 8 = 8'h01, 9 = 8'h09.
- Conversion FSM: IDLE → SHIFT → DONE → IDLE.
  - IDLE: capture data_in into a shadow register, clear the BCD accumulators, go to SHIFT. The capture cycle is cycle 0.
  - SHIFT: CONV_BITS cycles. Each cycle, add 3 to any BCD nibble ≥5, then shift left one bit from the shadow MSB. Both bytes are processed in parallel, 12-bit accumulator per byte.
  - DONE: load the display register, pulse upd, return to IDLE.
- Latency: fixed CONV_BITS+2 = 10 clocks from capture to display register load. The converter free-runs, one conversion per 10 clocks.
- data_in changes while busy are ignored; the next IDLE capture takes them.
- Marker words, checked on the captured value; same latency (FSM still walks SHIFT):
  - 16'hAAAA → all four digits DASH.
  - 16'hBBBB → all four BLANK.
- Range: a byte >99 (hundreds nibble ≠0) shows ERR,ERR in its two digits. The other byte is unaffected.
- Digit order, left to right: main tens, main ones, side tens, side ones.
- Scan:
  - The counter counts 0..SCAN_DIV-1 and wraps.
  - On wrap, sel advances 0→1→2→3→0.
  - AN/Seg register the selected digit one clock after the sel change.
  - AN = 4'b0111, 1011, 1101, 1110 for sel = 0..3.
- The display register is double-buffered: AN/Seg never show a mix of old and new conversions within one slot.

Optional Feature:
LEADING_ZERO_BLANK_EN
- Defined: a tens digit of 0 is shown as BLANK (e.g. 5 shows " 5"). Markers and ERR are unaffected.
- Undefined: a tens digit of 0 is shown as 0 ("05").

Decomposition:
- Package seg_pkg holds:
  - digit code constants (DASH, BLANK, ERR)
  - the 7-segment pattern table as a function
  - marker constants 16'hAAAA and 16'hBBBB
  - the AN one-hot table
- Sub-module bcd_dd_iter: one-byte iterative double-dabble with start/done, instantiated twice. The FSM shares a single control with both instances.

Test Plan:
- clr pulse mid-conversion, data_in = 16'h2328 → AN=1111 and Seg=FF immediately. First upd exactly 10 clks after clr falls, then display shows "3540".
- data_in = 16'h1E05 (30,5), SCAN_DIV=4 → AN cycles 0111/1011/1101/1110. Seg = 0D, 03, 03, 49; with LEADING_ZERO_BLANK_EN the third digit is FF.
- data_in = 16'hAAAA → all four slots Seg=FD. Then 16'hBBBB → all FF after ≤20 clks.
- data_in = 16'hC863 (200,99) → digits E,E,9,9 (Seg 61, 61, 09, 09).
- data_in toggled every 3 clks between 16'h0102 and 16'h0304 → upd spacing is exactly 10 clks. Every displayed value equals one complete captured word.
- Back-to-back: sel wrap coincides with the DONE cycle → the new value appears from the next slot only; the current slot's Seg is unchanged.
